// File: rtl/change_return_controller_pkg.sv
// Shared vending machine definitions: default sizes, FSM state encodings
// and the width of one packed price/coin slice.
package vending_machine_def;

    localparam int kNumCoins  = 3;
    localparam int kNumItems  = 4;
    localparam int kTotalBits = 32;

    // Every price and coin value occupies one 32-bit slice of its flattened bus
    localparam int kSliceBits = 32;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNTING = 2'd1,
        S_RETURN   = 2'd2
    } state_t;

    // Width used for balance comparisons so neither operand is truncated
    function automatic int cmp_width(input int total_bits);
        return (total_bits > kSliceBits) ? total_bits : kSliceBits;
    endfunction

endpackage

// File: rtl/change_return_controller_coin_selector.sv
// Combinational greedy coin picker: finds the largest denomination that
// still fits in the balance and reports it one-hot together with its value.
module coin_selector
    import vending_machine_def::*;
#(
    parameter int NUM_COINS  = kNumCoins,
    parameter int TOTAL_BITS = kTotalBits
) (
    input  logic [TOTAL_BITS-1:0]           total,
    input  logic [NUM_COINS*kSliceBits-1:0] coin_value,
    output logic [NUM_COINS-1:0]            coin_onehot,
    output logic [TOTAL_BITS-1:0]           coin_amount,
    output logic                            fits
);

    localparam int CMP_BITS = cmp_width(TOTAL_BITS);

    logic [CMP_BITS-1:0] total_ext;
    logic [CMP_BITS-1:0] slice_ext;

    assign total_ext = CMP_BITS'(total);

    // Denominations ascend with index, so the last fitting coin is the largest
    always_comb begin
        coin_onehot = '0;
        slice_ext   = '0;
        fits        = 1'b0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (CMP_BITS'(coin_value[k*kSliceBits +: kSliceBits]) <= total_ext) begin
                coin_onehot    = '0;
                coin_onehot[k] = 1'b1;
                slice_ext      = CMP_BITS'(coin_value[k*kSliceBits +: kSliceBits]);
                fits           = 1'b1;
            end
        end
    end

    assign coin_amount = slice_ext[TOTAL_BITS-1:0];

endmodule

// File: rtl/change_return_controller.sv
// Inactivity timer and change-return sequencer. Reloads the timer on coin
// inserts and affordable selections; on expiry or a user request it hands the
// balance back to the dispenser one largest-fitting coin per handshake.
module change_return_controller
    import vending_machine_def::*;
#(
    parameter int NUM_COINS      = kNumCoins,
    parameter int NUM_ITEMS      = kNumItems,
    parameter int TOTAL_BITS     = kTotalBits,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int TIMER_BITS     = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_COINS-1:0]            i_input_coin,
    input  logic [NUM_ITEMS-1:0]            i_select_item,
    input  logic                            i_trigger_return,
    input  logic [TOTAL_BITS-1:0]           i_current_total,
    input  logic [NUM_ITEMS*kSliceBits-1:0] i_item_price,
    input  logic [NUM_COINS*kSliceBits-1:0] i_coin_value,
    input  logic                            i_dispense_ready,
    output logic [NUM_COINS-1:0]            o_return_coin,
    output logic                            o_return_valid,
    output logic [TOTAL_BITS-1:0]           o_return_value,
    output logic [TIMER_BITS-1:0]           o_wait_time,
    output logic                            o_returning
);

    localparam int                    CMP_BITS = cmp_width(TOTAL_BITS);
    localparam logic [TIMER_BITS-1:0] RELOAD   = TIMER_BITS'(TIMEOUT_CYCLES);
    localparam logic [TIMER_BITS-1:0] ONE      = TIMER_BITS'(1);

    state_t                state_q;
    state_t                state_d;
    logic [TIMER_BITS-1:0] timer_q;
    logic [TIMER_BITS-1:0] timer_d;

    logic [CMP_BITS-1:0]   total_ext;
    logic                  select_affordable;
    logic                  activity;

    logic [NUM_COINS-1:0]  pick_onehot;
    logic [TOTAL_BITS-1:0] pick_amount;
    logic                  pick_fits;

    assign total_ext = CMP_BITS'(i_current_total);

    coin_selector #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_coin_selector (
        .total       (i_current_total),
        .coin_value  (i_coin_value),
        .coin_onehot (pick_onehot),
        .coin_amount (pick_amount),
        .fits        (pick_fits)
    );

    // Only the lowest-index selected item counts; scanning downward lets it win
    always_comb begin
        select_affordable = 1'b0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (i_select_item[i]) begin
                select_affordable = (total_ext >= CMP_BITS'(i_item_price[i*kSliceBits +: kSliceBits]));
            end
        end
    end

    assign activity = (|i_input_coin) || select_affordable;

    // State and timer registers, cleared asynchronously even mid-return
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state, timer and dispenser outputs; the return outputs depend only on state and balance
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        o_return_coin  = '0;
        o_return_valid = 1'b0;
        o_return_value = '0;
        o_returning    = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (i_trigger_return && pick_fits) begin
                    state_d = S_RETURN;
                end else if (activity) begin
                    state_d = S_COUNTING;
                    timer_d = RELOAD;
                end
            end
            S_COUNTING: begin
                if (i_trigger_return) begin
                    state_d = S_RETURN;
                    timer_d = '0;
                end else if (activity) begin
                    timer_d = RELOAD;
                end else if (timer_q <= ONE) begin
                    timer_d = '0;
                    state_d = pick_fits ? S_RETURN : S_IDLE;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            S_RETURN: begin
                timer_d     = '0;
                o_returning = 1'b1;
                if (pick_fits) begin
                    o_return_valid = 1'b1;
                    o_return_coin  = pick_onehot;
                    o_return_value = pick_amount;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign o_wait_time = timer_q;

endmodule

// File: tb/tb_change_return_controller.sv
// Bench for change_return_controller: a small datapath model drives the
// balance, and a reference model of the timer/return rules predicts outputs.
module tb_change_return_controller;

    localparam int T = 10;

    logic         clk;
    logic         reset_n;
    logic [2:0]   i_input_coin;
    logic [3:0]   i_select_item;
    logic         i_trigger_return;
    logic [31:0]  i_current_total;
    logic [127:0] i_item_price;
    logic [95:0]  i_coin_value;
    logic         i_dispense_ready;
    logic [2:0]   o_return_coin;
    logic         o_return_valid;
    logic [31:0]  o_return_value;
    logic [15:0]  o_wait_time;
    logic         o_returning;

    int cv[3] = '{100, 500, 1000};
    int pr[4] = '{400, 500, 1000, 2000};

    int compared;
    int mismatched;
    int tot;
    int m_remaining;
    bit m_returning;

    change_return_controller #(
        .NUM_COINS      (3),
        .NUM_ITEMS      (4),
        .TOTAL_BITS     (32),
        .TIMEOUT_CYCLES (T),
        .TIMER_BITS     (16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_select_item    (i_select_item),
        .i_trigger_return (i_trigger_return),
        .i_current_total  (i_current_total),
        .i_item_price     (i_item_price),
        .i_coin_value     (i_coin_value),
        .i_dispense_ready (i_dispense_ready),
        .o_return_coin    (o_return_coin),
        .o_return_valid   (o_return_valid),
        .o_return_value   (o_return_value),
        .o_wait_time      (o_wait_time),
        .o_returning      (o_returning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Largest denomination index not exceeding t, or -1 if none fits
    function automatic int fitIdx(input int t);
        int r = -1;
        for (int k = 0; k < 3; k++)
            if (cv[k] <= t) r = k;
        return r;
    endfunction

    // Price of the lowest-index selected item, or -1 with nothing selected
    function automatic int priceOf(input logic [3:0] sel);
        for (int i = 0; i < 4; i++)
            if (sel[i]) return pr[i];
        return -1;
    endfunction

    function automatic bit affordable(input logic [3:0] sel, input int t);
        int p = priceOf(sel);
        return (p >= 0) && (t >= p);
    endfunction

    // Compare every output with what the reference model predicts right now
    task automatic checkModel(input string tag);
        int  k;
        bit  v;
        k = fitIdx(tot);
        v = m_returning && (k >= 0);
        checkOutput({tag, ".valid"}, 64'(o_return_valid), 64'(v));
        checkOutput({tag, ".coin"},  64'(o_return_coin),  v ? 64'(3'b001 << k) : 64'd0);
        checkOutput({tag, ".value"}, 64'(o_return_value), v ? 64'(cv[k]) : 64'd0);
        checkOutput({tag, ".wait"},  64'(o_wait_time),    64'(m_remaining));
        if (!(m_returning && k < 0))
            checkOutput({tag, ".returning"}, 64'(o_returning), 64'(m_returning));
    endtask

    // One clock of stimulus: predicts the next balance and controller state, then checks
    task automatic applyStimulus(input logic [2:0] coin, input logic [3:0] sel, input logic trig, input logic rdy);
        int k;
        bit ev;
        int nt;
        k  = fitIdx(tot);
        ev = (coin != 3'b000) || affordable(sel, tot);
        nt = tot;
        if (m_returning && k >= 0 && rdy) nt -= cv[k];
        for (int i = 0; i < 3; i++)
            if (coin[i]) nt += cv[i];
        if (!m_returning && affordable(sel, tot)) nt -= priceOf(sel);

        if (m_returning) begin
            if (k < 0) m_returning = 1'b0;
        end else if (m_remaining == 0) begin
            if (trig && k >= 0) m_returning = 1'b1;
            else if (ev) m_remaining = T;
        end else begin
            if (trig) begin
                m_remaining = 0;
                m_returning = 1'b1;
            end else if (ev) begin
                m_remaining = T;
            end else begin
                m_remaining--;
                if (m_remaining == 0) m_returning = (k >= 0);
            end
        end

        i_input_coin     = coin;
        i_select_item    = sel;
        i_trigger_return = trig;
        i_dispense_ready = rdy;
        @(posedge clk);
        #1;
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        i_current_total  = nt;
        tot              = nt;
        @(negedge clk);
        checkModel("step");
    endtask

    task automatic setTotal(input int v);
        i_current_total = v;
        tot = v;
        #1;
    endtask

    // Directed scenarios followed by a randomized run against the model
    initial begin
        logic [2:0] rc;
        logic [3:0] rs;
        logic       rt;
        compared         = 0;
        mismatched       = 0;
        tot              = 0;
        m_remaining      = 0;
        m_returning      = 1'b0;
        reset_n          = 1'b0;
        i_input_coin     = '0;
        i_select_item    = '0;
        i_trigger_return = 1'b0;
        i_current_total  = '0;
        i_dispense_ready = 1'b1;
        i_coin_value     = {32'd1000, 32'd500, 32'd100};
        i_item_price     = {32'd2000, 32'd1000, 32'd500, 32'd400};

        repeat (3) @(negedge clk);
        checkOutput("rst.valid", 64'(o_return_valid), 64'd0);
        checkOutput("rst.wait",  64'(o_wait_time),    64'd0);
        reset_n = 1'b1;
        #1;
        checkModel("rst_release");
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);

        // Insert 500 and let the timer run out
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b1);
        checkOutput("timeout.reload", 64'(o_wait_time), 64'd10);
        for (int c = 0; c < 9; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        checkOutput("timeout.last", 64'(o_wait_time), 64'd1);
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        checkOutput("timeout.coin", 64'(o_return_coin), 64'(3'b010));
        for (int c = 0; c < 3; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);

        // Build 1700 and request a return
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b1);
        checkOutput("trig.value", 64'(o_return_value), 64'd1000);
        for (int c = 0; c < 6; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);

        // Unaffordable selection does not reload, affordable one does
        applyStimulus(3'b010, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b1000, 1'b0, 1'b1);
        checkOutput("sel.noreload", 64'(o_wait_time), 64'd7);
        applyStimulus(3'b000, 4'b0010, 1'b0, 1'b1);
        checkOutput("sel.reload", 64'(o_wait_time), 64'd10);
        for (int c = 0; c < 13; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);

        // Dispenser stalls for five cycles in RETURN
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
            checkOutput("stall.coin", 64'(o_return_coin), 64'(3'b100));
        end
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);

        // Residue of 50 at expiry goes straight back to idle
        setTotal(450);
        applyStimulus(3'b000, 4'b0001, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        checkOutput("residue.returning", 64'(o_returning), 64'd0);

        // Insert exactly on the timer==1 edge keeps counting
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 9; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        checkOutput("edge.one", 64'(o_wait_time), 64'd1);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b1);
        checkOutput("edge.reload", 64'(o_wait_time), 64'd10);
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a return
        applyStimulus(3'b100, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b000, 4'b0000, 1'b1, 1'b0);
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset.valid",     64'(o_return_valid), 64'd0);
        checkOutput("areset.coin",      64'(o_return_coin),  64'd0);
        checkOutput("areset.value",     64'(o_return_value), 64'd0);
        checkOutput("areset.returning", 64'(o_returning),    64'd0);
        m_remaining = 0;
        m_returning = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkModel("areset_release");
        applyStimulus(3'b000, 4'b0000, 1'b0, 1'b1);
        applyStimulus(3'b001, 4'b0000, 1'b0, 1'b1);
        checkOutput("areset.fresh", 64'(o_wait_time), 64'd10);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rc = ($urandom_range(0, 5) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
            rs = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            rt = ($urandom_range(0, 29) == 0);
            if (tot > 20000) rc = 3'b000;
            if (rt && !m_returning && m_remaining == 0) begin
                rc = 3'b000;
                rs = 4'b0000;
            end
            applyStimulus(rc, rs, rt, $urandom_range(0, 9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/change_return_controller.md
Name: change_return_controller

Overview:
Parametrised successor to the vending machine's time-and-coin checker. It owns the inactivity timer and the change-return sequence. The timer reloads on every coin insert and every affordable selection. When the timer expires, or a return is requested, the block enters a return state and dispenses the balance greedily, one coin per handshake, until the balance drops below the smallest coin. It sits between the balance datapath, which owns current_total, and the coin dispenser.

Parameters:
NUM_COINS, 3, number of coin denominations; index 0 is the smallest, values strictly ascending
NUM_ITEMS, 4, number of selectable items
TOTAL_BITS, 32, width of the balance
TIMEOUT_CYCLES, 100, inactivity cycles before automatic return (>=1)
TIMER_BITS, 16, width of the timer (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
i_input_coin  in  NUM_COINS  per-cycle coin-insert strobes
i_select_item  in  NUM_ITEMS  per-cycle item-select strobes
i_trigger_return  in  1  user return request, single-cycle strobe
i_current_total  in  TOTAL_BITS  balance from the datapath, updated on the edge after any deduction
i_item_price  in  NUM_ITEMS*32  flattened prices; item i occupies [32i+31:32i]
i_coin_value  in  NUM_COINS*32  flattened coin values, same packing
i_dispense_ready  in  1  dispenser can accept a coin this cycle
o_return_coin  out  NUM_COINS  one-hot coin to dispense; all-zero when o_return_valid=0
o_return_valid  out  1  return request to the dispenser
o_return_value  out  TOTAL_BITS  value of o_return_coin; the datapath subtracts it when valid&ready
o_wait_time  out  TIMER_BITS  remaining inactivity cycles
o_returning  out  1  high in the RETURN state

Behaviour:
- Reset (asynchronous, any state, including mid-return): state=IDLE, timer=0. All outputs are 0 during reset and on the first edge after deassertion.
- States: IDLE, COUNTING, RETURN.
- Activity event: i_input_coin != 0, or the lowest-index set bit i of i_select_item has i_current_total >= price[i]. An unaffordable selection is not an event and leaves the timer untouched.
- IDLE: on an activity event, timer<=TIMEOUT_CYCLES and go to COUNTING. On i_trigger_return with total >= coin_value[0], go to RETURN. Otherwise hold.
- COUNTING:
  - Priority: i_trigger_return > activity event > decrement.
  - Trigger: go to RETURN and set timer<=0.
  - Activity event: reload timer<=TIMEOUT_CYCLES.
  - Otherwise timer<=timer-1.
  - When timer==1 and there is no event or trigger, the next edge sets timer=0 and goes to RETURN if total >= coin_value[0], else to IDLE.
  - Net effect: RETURN begins exactly TIMEOUT_CYCLES edges after the last event edge.
- RETURN:
  - o_returning=1 and o_return_valid=1 when total >= coin_value[0]. o_return_coin selects the largest index k with coin_value[k] <= total. o_return_value = coin_value[k].
  - These outputs are combinational from state and i_current_total.
  - A coin is transferred on each edge where valid&ready. The datapath deducts it on that same edge.
  - When total < coin_value[0], go to IDLE with valid low; no transfer happens that cycle.
  - Coin inserts, selections and triggers during RETURN are ignored by this block and do not reload the timer. The datapath still credits inserted coins, so they are returned as part of the sequence.
  - A total of 0 at expiry goes straight to IDLE; nothing is dispensed.
  - The residue below the smallest coin stays in the balance.
- i_dispense_ready low: outputs hold stable and the state stays RETURN, with no timeout.
- o_wait_time = timer register. It is 0 in IDLE and RETURN.
- Widths: price and coin comparisons are zero-extended to max(32, TOTAL_BITS).

Decomposition:
- Shared package vending_machine_def holds:
  - kNumCoins, kNumItems, kTotalBits defaults
  - state encodings S_IDLE=2'd0, S_COUNTING=2'd1, S_RETURN=2'd2
  - the 32-bit price/coin slice width constant
- One sub-module, coin_selector (combinational): takes total and the coin vector, and outputs the one-hot largest-fitting coin, its value and a fits flag.
- The FSM, timer and event detection stay in the top level.

Test Plan:
- Setup for all scenarios: TIMEOUT_CYCLES=10; coins 100/500/1000; prices 400/500/1000/2000.
- Insert coin 500, then idle: o_wait_time=10 then counts down to 1. On the 10th edge o_returning=1, o_return_coin=3'b010, o_return_value=500. With ready=1, one transfer, then IDLE, and o_wait_time stays 0.
- Total 1700 with i_trigger_return in COUNTING: RETURN on the next edge, coins dispensed 1000, 500, 100, 100 on consecutive ready cycles, then IDLE.
- Select item 3 (2000) at total 600: no reload, and the timer keeps decrementing. Select item 1 (500) at total 600: timer reloads to 10.
- In RETURN with total 1000, hold i_dispense_ready=0 for 5 cycles: o_return_coin=3'b100 stable and state unchanged. Raise ready: one transfer, then IDLE.
- Total 50 at expiry: IDLE directly, o_return_valid never asserted. Coin insert on the same edge as timer==1: timer reloads to 10 and the block stays in COUNTING.
- Assert reset_n=0 asynchronously mid-RETURN (between edges): all outputs 0 immediately. After release the state is IDLE and a fresh insert starts the timer at 10.
